sap_loader: RTL and testbench

SAP_LOADER -- requirements
Module: sap_loader

---
 rtl/sap_pkg.sv | 18 +
 rtl/sap_checksum.sv | 28 ++
 rtl/sap_loader.sv | 149 ++++++++++++++
 tb/tb_sap_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 RAM loader: bus widths and loader states.
// The CHK state exists only when SAP_LOADER_CHECKSUM_EN is defined.
package sap_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef SAP_LOADER_CHECKSUM_EN
    CHK,
`endif
    RST,
    RUN
  } loader_state_e;

endpackage : sap_pkg

// File: rtl/sap_checksum.sv
// Running mod-256 sum of the words loaded in a session.
// zero reports whether adding the byte currently on data would bring the
// sum to 0x00, so the checksum byte can be judged in the cycle it arrives.
module sap_checksum
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic              zero
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_next;

  assign sum_next = sum_q + data;
  assign zero     = (sum_next == '0);

  // Accumulate each accepted RAM word; restart at the beginning of a session.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sum_q <= '0;
    else if (clear) sum_q <= '0;
    else if (add)   sum_q <= sum_next;
  end

endmodule : sap_checksum

// File: rtl/sap_loader.sv
// Loads a SAP-1 CPU RAM image from a valid/ready byte stream, then holds the
// CPU in reset for RESET_CYCLES cycles and releases it into run mode.
// Optional feature: define SAP_LOADER_CHECKSUM_EN to require a trailing
// checksum byte that makes the mod-256 sum of the image plus itself 0x00.
module sap_loader
  import sap_pkg::*;
#(
  parameter int LOAD_DEPTH   = 16,
  parameter int RESET_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              program_mode,
  output logic [DATA_W-1:0] program_data,
  output logic [ADDR_W-1:0] program_address,
  output logic              sap_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [3:0]        rst_cnt_q;
  logic              handshake;
  logic              load_hs;
  logic              last_word;
  logic              rst_last;
  logic              session_start;

  assign handshake     = in_valid && in_ready;
  assign load_hs       = handshake && (state_q == LOAD);
  assign last_word     = (cnt_q == ADDR_W'(LOAD_DEPTH - 1));
  assign rst_last      = (rst_cnt_q == 4'(RESET_CYCLES - 1));
  assign session_start = start && ((state_q == IDLE) || (state_q == RUN));

`ifdef SAP_LOADER_CHECKSUM_EN
  logic cks_zero;

  sap_checksum u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (session_start),
    .add   (load_hs),
    .data  (in_data),
    .zero  (cks_zero)
  );
`endif

  // State register; every output that depends only on state follows it
  // combinationally, so an asserted reset shows on the outputs at once.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and state-derived outputs.
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    program_mode = 1'b0;
    sap_reset    = 1'b1;
    busy         = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake && last_word) begin
`ifdef SAP_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = RST;
`endif
        end
      end
`ifdef SAP_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake) state_d = cks_zero ? RST : IDLE;
      end
`endif
      RST: begin
        busy = 1'b1;
        if (rst_last) state_d = RUN;
      end
      RUN: begin
        program_mode = 1'b1;
        sap_reset    = 1'b0;
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word counter: cleared at session start, saturates on the last word.
  // NOTE: only control/datapath registers take the async reset; the SAP RAM
  // itself lives outside and is deliberately not cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt_q <= '0;
    else if (session_start)         cnt_q <= '0;
    else if (load_hs && !last_word) cnt_q <= cnt_q + ADDR_W'(1);
  end

  // RAM write port registers: capture on each LOAD handshake, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      program_data    <= '0;
      program_address <= '0;
    end else if (load_hs) begin
      program_data    <= in_data;
      program_address <= cnt_q;
    end
  end

  // CPU-reset hold counter: runs only while in RST, idles at zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               rst_cnt_q <= '0;
    else if (state_q != RST) rst_cnt_q <= '0;
    else                     rst_cnt_q <= rst_cnt_q + 4'd1;
  end

  // done pulses in the first RUN cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state_d == RUN) && (state_q != RUN);
  end

`ifdef SAP_LOADER_CHECKSUM_EN
  // Sticky checksum failure, cleared when a new session starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     err <= 1'b0;
    else if (session_start)                        err <= 1'b0;
    else if (state_q == CHK && handshake && !cks_zero) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule : sap_loader

// File: tb/tb_sap_loader.sv
// Self-checking bench for sap_loader: fixed demo image, stalls, mid-load
// reset, ignored/reload starts, random images, and a LOAD_DEPTH=4 instance.
// Expected RAM writes come from the bench's own image array; the checksum
// byte (when SAP_LOADER_CHECKSUM_EN is defined) is computed from the image.
module tb_sap_loader;

  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, program_mode, sap_reset, busy, done, err;
  logic [7:0] program_data;
  logic [3:0] program_address;

  logic       start4 = 1'b0;
  logic       in_valid4 = 1'b0;
  logic       in_ready_4, program_mode_4, sap_reset_4, busy_4, done_4, err_4;
  logic [7:0] program_data_4;
  logic [3:0] program_address_4;

  int checks = 0;
  int errors = 0;

  logic [7:0] stream [16];
  logic [7:0] demo   [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
                              8'h00, 8'h0E, 8'h15, 8'h01, 8'h07, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  sap_loader #(.LOAD_DEPTH(16), .RESET_CYCLES(RC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .program_mode(program_mode), .program_data(program_data),
    .program_address(program_address), .sap_reset(sap_reset), .busy(busy),
    .done(done), .err(err)
  );

  sap_loader #(.LOAD_DEPTH(4), .RESET_CYCLES(RC)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_data(in_data), .in_valid(in_valid4),
    .in_ready(in_ready_4), .program_mode(program_mode_4), .program_data(program_data_4),
    .program_address(program_address_4), .sap_reset(sap_reset_4), .busy(busy_4),
    .done(done_4), .err(err_4)
  );

  // Checksum byte that brings the mod-256 sum of the current image to zero.
  function automatic logic [7:0] good_cks();
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(stream[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, program_mode, sap_reset, busy, done, err, program_address, program_data}
        !== {6'b001000, 4'h0, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: got %b want %b",
               {in_ready, program_mode, sap_reset, busy, done, err, program_address, program_data},
               {6'b001000, 4'h0, 8'h00});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, program_mode, sap_reset, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 0010", {in_ready, program_mode, sap_reset, busy});
    end
  endtask

  // One full session on the main DUT from IDLE or RUN. stall_at>0 drops
  // in_valid for stall_len cycles before that word; poke_start pulses start
  // during LOAD and RST; cks_good selects the trailing byte when enabled.
  task automatic run_session(input int stall_at, input int stall_len,
                             input bit poke_start, input bit cks_good);
    bit seen;
    int c;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if ({program_mode, sap_reset, busy, in_ready, done} !== 5'b01110) begin
      errors++;
      $display("FAIL session_entry: got %b want 01110", {program_mode, sap_reset, busy, in_ready, done});
    end
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at && i > 0) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          checks++;
          if ({in_ready, program_address, program_data} !== {1'b1, 4'(i - 1), stream[i - 1]}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got %h want %h", s,
                     {in_ready, program_address, program_data}, {1'b1, 4'(i - 1), stream[i - 1]});
          end
        end
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      if (poke_start && i == 5) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++;
      if ({program_address, program_data} !== {4'(i), stream[i]}) begin
        errors++;
        $display("FAIL write[%0d]: got addr %h data %h want addr %h data %h",
                 i, program_address, program_data, 4'(i), stream[i]);
      end
    end
    in_valid = 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      errors++;
      $display("FAIL chk_state: got %b want 11", {in_ready, busy});
    end
    in_valid = 1'b1;
    in_data  = cks_good ? good_cks() : good_cks() + 8'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    if (!cks_good) begin
      checks++;
      if ({err, busy, program_mode, sap_reset, in_ready} !== 5'b10010) begin
        errors++;
        $display("FAIL cks_bad: got %b want 10010", {err, busy, program_mode, sap_reset, in_ready});
      end
      return;
    end
`endif
    checks++;
    if ({in_ready, program_mode, sap_reset, busy, err} !== 5'b00110) begin
      errors++;
      $display("FAIL rst_state: got %b want 00110", {in_ready, program_mode, sap_reset, busy, err});
    end
    if (poke_start) start = 1'b1;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 20) begin
      @(posedge clk); #1 start = 1'b0;
      c++;
      if (program_mode) seen = 1'b1;
    end
    checks++;
    if (!seen || c != RC) begin
      errors++;
      $display("FAIL rst_length: got %0d cycles (reached=%0d) want %0d", c, seen, RC);
    end
    checks++;
    if ({done, sap_reset, busy, program_address, program_data} !== {3'b100, 4'hF, stream[15]}) begin
      errors++;
      $display("FAIL run_entry: got %h want %h",
               {done, sap_reset, busy, program_address, program_data}, {3'b100, 4'hF, stream[15]});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, program_mode, in_ready} !== 3'b010) begin
      errors++;
      $display("FAIL done_pulse: got %b want 010", {done, program_mode, in_ready});
    end
  endtask

  task automatic test_demo();
    for (int i = 0; i < 16; i++) stream[i] = demo[i];
    run_session(-1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) stream[i] = demo[i];
    run_session(4, 5, 1'b0, 1'b1);
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    run_session(-1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 16; i++) stream[i] = demo[i];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      @(posedge clk); #1;
    end
    in_data = stream[7];
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, program_mode, sap_reset, busy, done, err, program_address, program_data}
        !== {6'b001000, 4'h0, 8'h00}) begin
      errors++;
      $display("FAIL mid_load_reset: got %b want %b",
               {in_ready, program_mode, sap_reset, busy, done, err, program_address, program_data},
               {6'b001000, 4'h0, 8'h00});
    end
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    run_session(-1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random_reload();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
      run_session(int'($urandom_range(1, 15)), int'($urandom_range(1, 4)), 1'b0, 1'b1);
    end
  endtask

`ifdef SAP_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    for (int i = 0; i < 16; i++) stream[i] = demo[i];
    run_session(-1, 0, 1'b0, 1'b0);
    run_session(-1, 0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_depth4();
    bit seen;
    int c;
    logic [7:0] b [4];
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b[i]      = 8'($urandom);
      in_valid4 = 1'b1;
      in_data   = b[i];
      @(posedge clk); #1;
      checks++;
      if ({program_address_4, program_data_4} !== {4'(i), b[i]}) begin
        errors++;
        $display("FAIL d4_write[%0d]: got %h want %h", i,
                 {program_address_4, program_data_4}, {4'(i), b[i]});
      end
    end
`ifdef SAP_LOADER_CHECKSUM_EN
    in_data = 8'((256 - ((int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256)) % 256);
    @(posedge clk); #1;
`endif
    in_valid4 = 1'b0;
    checks++;
    if ({in_ready_4, busy_4, sap_reset_4, program_address_4} !== {3'b011, 4'h3}) begin
      errors++;
      $display("FAIL d4_rst: got %h want %h", {in_ready_4, busy_4, sap_reset_4, program_address_4},
               {3'b011, 4'h3});
    end
    seen = 1'b0;
    c = 0;
    while (!seen && c < 20) begin
      @(posedge clk); #1;
      c++;
      if (program_mode_4) seen = 1'b1;
    end
    checks++;
    if (!seen || c != RC || done_4 !== 1'b1 || program_address_4 !== 4'h3) begin
      errors++;
      $display("FAIL d4_run: got cycles %0d reached %0d done %b addr %h want cycles %0d done 1 addr 3",
               c, seen, done_4, program_address_4, RC);
    end
  endtask

  initial begin
    test_reset();
    test_demo();
    test_stall();
    test_start_ignored();
    test_reset_mid_load();
    test_random_reload();
`ifdef SAP_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_depth4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_sap_loader
